// File: rtl/kbd_pkg.sv
// kbd_pkg: shared FSM state type, code-width helper and reset column for the keypad scanner
package kbd_pkg;
    typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;
    localparam int unsigned COL_RST = 1;
    function automatic int code_w(input int width);
        return 2 * $clog2(width);
    endfunction
endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous FIFO with registered head and a one-cycle drop pulse
//   push/din  : write request and data; dropped when full unless popped the same cycle
//   pop       : consume the head (ignored when empty)
//   dout      : head entry, read from storage registers
//   empty     : no entries stored
//   drop      : high the cycle after a push was discarded
module kbd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              drop
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic full, do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_pop  = pop && !empty;
    // When full, the simultaneous pop frees the slot the write pointer aims at.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            drop <= push && !do_push;
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
            end
            if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/control_teclado.sv
// control_teclado: keypad matrix scanner with press/release debounce and key-code FIFO
//   fil       : raw row inputs (asynchronous, synchronized here)
//   col       : one-hot column drive
//   key_code  : FIFO head {row_idx, col_idx}; key_valid/key_ready handshake
//   overflow  : one-cycle pulse when an accepted key was dropped on a full FIFO
//   busy      : registered "not scanning" flag
module control_teclado
    import kbd_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_PULSES = 3,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W         = code_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  fil,
    output logic [WIDTH-1:0]  col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow,
    output logic              busy
);
    localparam int IW = $clog2(WIDTH);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_PULSES + 1);
    state_t state, state_n;
    logic [WIDTH-1:0] fil_m, fil_s, col_n, rot;
    logic [DW-1:0] dw;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] row_idx, row_n, col_idx, ci_n, low_row, cur_ci;
    logic sample, push_r, push_n, hit, last, fifo_empty;
    assign sample = dw == DW'(SCAN_DIV - 1);
    assign rot    = {col[WIDTH-2:0], col[WIDTH-1]};
    assign hit    = fil_s[row_idx];
    assign last   = int'(cnt) + 1 == DEBOUNCE_PULSES;
    always_comb begin
        low_row = '0;
        cur_ci  = '0;
        // Descending scan so the lowest set row wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            low_row = fil_s[i] ? IW'(i) : low_row;
            cur_ci  = col[i] ? IW'(i) : cur_ci;
        end
    end
    always_comb begin
        state_n = state;
        col_n   = col;
        cnt_n   = cnt;
        row_n   = row_idx;
        ci_n    = col_idx;
        push_n  = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (|fil_s) begin
                        row_n = low_row;
                        ci_n  = cur_ci;
                        if (DEBOUNCE_PULSES == 1) begin
                            push_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = CONFIRM;
                        end
                    end else begin
                        col_n = rot;
                    end
                end
                CONFIRM: begin
                    if (hit) begin
                        push_n  = last;
                        cnt_n   = last ? '0 : cnt + 1'b1;
                        state_n = last ? HELD : CONFIRM;
                    end else begin
                        cnt_n   = '0;
                        col_n   = rot;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (hit) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n   = last ? '0 : cnt + 1'b1;
                        col_n   = last ? rot : col;
                        state_n = last ? SCAN : HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fil_m   <= '0;
            fil_s   <= '0;
            dw      <= '0;
            state   <= SCAN;
            col     <= WIDTH'(COL_RST);
            cnt     <= '0;
            row_idx <= '0;
            col_idx <= '0;
            push_r  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            fil_m   <= fil;
            fil_s   <= fil_m;
            dw      <= sample ? '0 : dw + 1'b1;
            state   <= state_n;
            col     <= col_n;
            cnt     <= cnt_n;
            row_idx <= row_n;
            col_idx <= ci_n;
            push_r  <= push_n;
            busy    <= state != SCAN;
        end
    end
    kbd_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(CODE_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .pop   (key_ready),
        .din   ({row_idx, col_idx}),
        .dout  (key_code),
        .empty (fifo_empty),
        .drop  (overflow)
    );
    assign key_valid = !fifo_empty;
endmodule

// File: tb/tb_control_teclado.sv
// tb_control_teclado: scenario tasks with a key-matrix model and an expected-code scoreboard
module tb_control_teclado;
    localparam int W    = 4;
    localparam int SD   = 16;
    localparam int DP   = 3;
    localparam int FD   = 4;
    localparam int CW   = 4;
    localparam int HOLD = (W + DP) * SD + 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_ready = 1'b0;
    logic [W-1:0] fil, col;
    logic [CW-1:0] key_code;
    logic key_valid, overflow, busy;
    logic [W-1:0] keys [W] = '{default: '0};
    logic [CW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;

    control_teclado #(.WIDTH(W), .SCAN_DIV(SD), .DEBOUNCE_PULSES(DP), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key at (r,c) pulls row r high while column c is driven.
    always_comb begin
        fil = '0;
        for (int c = 0; c < W; c++) if (col[c]) fil = fil | keys[c];
    end

    always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] code(input int r, input int c);
        return CW'(r * W + c);
    endfunction

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b after %0d cycles, want 0", name, busy, t);
        end
    endtask

    task automatic tap(input int r, input int c, input bit expect_push);
        keys[c] = W'(1 << r);
        if (expect_push) exp_q.push_back(code(r, c));
        repeat (HOLD) @(posedge clk);
        #1 keys[c] = '0;
        wait_idle("tap");
        repeat (SD) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input string name);
        int got = 0;
        int t = 0;
        logic [CW-1:0] e;
        @(posedge clk); #1 key_ready = 1'b1;
        while (got < n && t < 60) begin
            @(negedge clk);
            t++;
            if (key_valid === 1'b1) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = 'x;
                checks++;
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL %s code[%0d]: got %b, want %b", name, got, key_code, e);
                end
                got++;
            end
        end
        @(posedge clk); #1 key_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s count: got %0d codes, want %0d", name, got, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (col !== 4'b0001) begin errors++; $display("FAIL reset col: got %b, want 0001", col); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, want 0", busy); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset key_valid: got %b, want 0", key_valid); end
        if (key_code !== 4'b0000) begin errors++; $display("FAIL reset key_code: got %b, want 0000", key_code); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b, want 0", overflow); end
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (col !== 4'b0001) begin errors++; $display("FAIL dwell hold col: got %b, want 0001", col); end
        @(posedge clk); #1;
        checks++;
        if (col !== 4'b0010) begin errors++; $display("FAIL dwell rotate col: got %b, want 0010", col); end
    endtask

    task automatic test_clean_press;
        int t = 0;
        int bad = 0;
        keys[1] = 4'b0100;
        exp_q.push_back(code(2, 1));
        while (key_valid !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (key_valid !== 1'b1 || t > 116) begin
            errors++;
            $display("FAIL clean latency: key_valid=%b after %0d cycles, want 1 within 116", key_valid, t);
        end
        repeat (48) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clean busy held: %0d cycles low, want 0", bad); end
        keys[1] = '0;
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (busy !== 1'b0 || t < 2 * SD) begin
            errors++;
            $display("FAIL clean release debounce: busy=%b after %0d cycles, want 0 after >= %0d", busy, t, 2 * SD);
        end
        drain(1, "clean");
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (key_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || ovf_cnt != 0) begin
            errors++;
            $display("FAIL clean single code: extra valid cycles=%0d overflow=%0d, want 0 and 0", bad, ovf_cnt);
        end
    endtask

    task automatic test_bounce;
        int t = 0;
        int v = 0;
        while (col === 4'b0010 && t < 100) begin @(negedge clk); t++; end
        while (col !== 4'b0010 && t < 100) begin @(negedge clk); t++; end
        keys[1] = 4'b0001;
        t = 0;
        while (busy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bounce detect: busy=%b, want 1", busy); end
        keys[1] = '0;
        t = 0;
        while (busy !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
            if (key_valid !== 1'b0) v++;
        end
        checks++;
        if (busy !== 1'b0 || col !== 4'b0100) begin
            errors++;
            $display("FAIL bounce reject: busy=%b col=%b, want 0 and 0100", busy, col);
        end
        repeat (100) begin
            @(negedge clk);
            if (key_valid !== 1'b0) v++;
        end
        checks++;
        if (v != 0) begin errors++; $display("FAIL bounce no push: key_valid high %0d cycles, want 0", v); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous;
        int t = 0;
        int v = 0;
        keys[0] = 4'b1010;
        exp_q.push_back(code(1, 0));
        while (key_valid !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL simul first: key_valid=%b, want 1", key_valid); end
        drain(1, "simul row1");
        repeat (64) begin
            @(negedge clk);
            if (key_valid !== 1'b0 || busy !== 1'b1) v++;
        end
        checks++;
        if (v != 0) begin errors++; $display("FAIL simul row3 ignored: %0d bad cycles, want 0", v); end
        @(posedge clk); #1 keys[0] = 4'b1000;
        exp_q.push_back(code(3, 0));
        t = 0;
        while (key_valid !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL simul second: key_valid=%b, want 1", key_valid); end
        drain(1, "simul row3");
        keys[0] = '0;
        wait_idle("simul");
        repeat (SD) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        int ovf0;
        ovf0 = ovf_cnt;
        tap(0, 1, 1'b1);
        tap(1, 2, 1'b1);
        tap(2, 3, 1'b1);
        tap(3, 0, 1'b1);
        checks++;
        if (ovf_cnt != ovf0) begin errors++; $display("FAIL overflow early: got %0d pulses, want 0", ovf_cnt - ovf0); end
        tap(1, 0, 1'b0);
        checks++;
        if (ovf_cnt != ovf0 + 1) begin errors++; $display("FAIL overflow fifth: got %0d pulses, want 1", ovf_cnt - ovf0); end
        drain(4, "overflow");
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL overflow empty: key_valid=%b, want 0", key_valid); end
    endtask

    task automatic test_full_push_pop;
        int t = 0;
        int ovf0;
        logic [CW-1:0] e;
        tap(0, 0, 1'b1);
        tap(1, 1, 1'b1);
        tap(2, 2, 1'b1);
        tap(3, 3, 1'b1);
        ovf0 = ovf_cnt;
        keys[2] = 4'b1000;
        while (busy !== 1'b1 && t < 120) begin @(posedge clk); #1; t++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full detect: busy=%b, want 1", busy); end
        // Push lands on the edge 32 cycles after busy rose (two more dwell samples, +1 register).
        repeat (31) @(posedge clk);
        #1 key_ready = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (key_code !== e) begin errors++; $display("FAIL full head: got %b, want %b", key_code, e); end
        @(posedge clk); #1 key_ready = 1'b0;
        exp_q.push_back(code(3, 2));
        repeat (40) @(posedge clk);
        #1 keys[2] = '0;
        wait_idle("full");
        checks++;
        if (ovf_cnt != ovf0) begin errors++; $display("FAIL full no overflow: got %0d pulses, want 0", ovf_cnt - ovf0); end
        drain(4, "full");
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL full count: key_valid=%b after 4 pops, want 0", key_valid); end
    endtask

    task automatic test_reset_confirm;
        int t = 0;
        int v = 0;
        keys[2] = 4'b0001;
        while (busy !== 1'b1 && t < 120) begin @(posedge clk); #1; t++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstconf detect: busy=%b, want 1", busy); end
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        keys[2] = '0;
        @(posedge clk); #1;
        checks += 3;
        if (col !== 4'b0001) begin errors++; $display("FAIL rstconf col: got %b, want 0001", col); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstconf busy: got %b, want 0", busy); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL rstconf key_valid: got %b, want 0", key_valid); end
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (key_valid !== 1'b0) v++;
        end
        checks++;
        if (v != 0) begin errors++; $display("FAIL rstconf no push: key_valid high %0d cycles, want 0", v); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_reset_confirm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_teclado.md
# control_teclado

Keypad scan controller for the row/column matrix front end. It drives the one-hot column strobe and samples the synchronized row inputs at the end of each column dwell. It freezes the scan on a candidate key, debounces both press and release, and pushes one `{row,col}` code per accepted press into a small FIFO. Downstream logic drains the FIFO through a valid/ready interface. This block replaces free-running scan plus ad-hoc debounce at the top of the keypad read path.

## Interface
- `WIDTH`, 4: number of rows and columns (square matrix); must be ≥2 and a power of 2.
- `SCAN_DIV`, 16: clock cycles each column is driven (dwell); must be ≥4.
- `DEBOUNCE_PULSES`, 3: consecutive matching dwell-end samples needed to accept a press or a release; must be ≥1.
- `FIFO_DEPTH`, 4: key-code buffer entries; must be a power of 2.
- `clk` in 1: single clock; everything is in this domain.
- `rst` in 1: reset; synchronous, active-high.
- `fil` in WIDTH: raw row inputs (asynchronous).
- `col` out WIDTH: one-hot column drive.
- `key_code` out CODE_W = 2·$clog2(WIDTH): FIFO head, `{row_idx, col_idx}`.
- `key_valid` out 1: FIFO not empty.
- `key_ready` in 1: consumer accepts head when high with `key_valid`.
- `overflow` out 1: one-cycle pulse when an accepted key was dropped because the FIFO was full.
- `busy` out 1: high in any state other than SCAN.

## Operation
- `fil` passes through a 2-flop synchronizer (`fil_s`). Only `fil_s` is used.
- Dwell counter `dw` counts 0..SCAN_DIV-1 and wraps. The sample point is `dw == SCAN_DIV-1`.
- FSM states: SCAN, CONFIRM, HELD.
- **SCAN:**
  - `col` rotates left, wrapping MSB→LSB, on the cycle after each sample point.
  - At a sample point with `|fil_s`: capture `row_idx` as the lowest set bit of `fil_s`, and `col_idx` as the current column index.
  - Then set `cnt=1`, freeze `col`, and go to CONFIRM. If DEBOUNCE_PULSES==1, go straight to push + HELD.
- **CONFIRM:**
  - `col` stays frozen. At each sample point, check `fil_s[row_idx]`.
  - If high: increment `cnt`. When `cnt+1 == DEBOUNCE_PULSES`, push the code, clear `cnt`, and go to HELD.
  - If low: clear `cnt`, advance `col` one position, and go to SCAN (false press, nothing pushed).
- **HELD:**
  - `col` stays frozen. At each sample point, check `fil_s[row_idx]`.
  - If low: increment `cnt`. When DEBOUNCE_PULSES consecutive lows are reached, advance `col` and go to SCAN.
  - If high: clear `cnt`.
  - No auto-repeat: exactly one code per press.
- Rows other than `row_idx` are ignored outside SCAN.
- **FIFO:**
  - A push when full (with no pop that cycle) drops the new code and pulses `overflow`.
  - A push and pop in the same cycle when full is accepted, and the count is unchanged.
  - A pop when empty is impossible because `key_valid=0`.
  - Order is preserved.
- **Reset values:**
  - `col = 1` (one-hot bit 0), state SCAN, `dw=0`, `cnt=0`.
  - Synchronizers 0, FIFO empty.
  - `key_valid=0`, `key_code=0`, `overflow=0`, `busy=0`.
- Reset asserted mid-CONFIRM or mid-HELD abandons the pending key. Nothing is pushed.

## Timing
- `fil` to `fil_s` latency: 2 cycles.
- A `col` change is visible the cycle after its sample point. Rows therefore settle SCAN_DIV-1 cycles before the next sample, which is why SCAN_DIV ≥4.
- The push occurs on the cycle after the accepting sample point. `key_valid` rises the cycle after the push when the FIFO was empty.
- Press-to-`key_valid` for a clean, stable press: at most (WIDTH + DEBOUNCE_PULSES)·SCAN_DIV + 4 cycles.
- `key_code` is registered from the FIFO head. It updates the cycle after a pop.
- `overflow` is high for exactly the push cycle's successor (1 cycle).
- `busy` is registered from the state and changes the cycle after the transition.

## Structure
- Shared package `kbd_pkg`:
  - `state_t` enum (SCAN, CONFIRM, HELD).
  - Function `code_w(width)` returning `2*$clog2(width)`.
  - Constant for the reset one-hot column.
- Sub-module `kbd_fifo`: parameterized synchronous FIFO (DEPTH, DATA_W) with push/pop, full/empty and a drop flag. Instantiated once.
- Scan/FSM logic lives in `control_teclado`.

## Test plan
- **Clean press.** WIDTH=4, SCAN_DIV=16, DEBOUNCE_PULSES=3. Hold `fil=4'b0100` only while `col=4'b0010` across rotations.
  - Exactly one code `4'b1001` (row 2, col 1), with `key_valid` within 116 cycles of the first press.
  - `busy` stays high until release is debounced.
- **Bounce rejection.** Assert the row for 1 dwell sample, then drop it.
  - No push; FSM returns to SCAN; `col` advances to `4'b0100`.
  - `key_valid` stays 0.
- **Simultaneous rows.** `fil=4'b1010` at `col=4'b0001`, held.
  - Code `4'b0100` (row 1, col 0). Row 3 is ignored until release.
- **Overflow.** Hold `key_ready=0` and make 5 distinct clean presses.
  - FIFO returns the first 4 codes in order when `key_ready=1`.
  - `overflow` pulses once, on the 5th push.
- **Full push+pop.** FIFO full; `key_ready=1` in the same cycle as a new push.
  - No `overflow`; count stays 4; the new code appears last.
- **Reset mid-CONFIRM.** Assert `rst` after the 2nd confirming sample.
  - Next cycle: `col=4'b0001`, `busy=0`, `key_valid=0`, and no code pushed.
